// File: rtl/div_seq_radix2.sv
// div_seq_radix2: multi-cycle unsigned restoring divider, one quotient bit per clock, valid/ready on both sides
module div_seq_radix2 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy
);
    localparam int CW = $clog2(DIVIDEND_W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_next;
    // acc starts as the dividend and fills with quotient bits from the LSB as it shifts
    logic [DIVIDEND_W-1:0] acc;
    logic [DIVISOR_W-1:0]  dvs;
    // stored partial remainder is always < divisor, so DIVISOR_W bits suffice; the shifted value needs one more
    logic [DIVISOR_W-1:0]  pr;
    logic [DIVISOR_W:0]    pr_shift;
    logic [DIVISOR_W-1:0]  pr_step;
    logic [CW-1:0]         cnt;
    logic                  accept, fits, last;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == '0;
    assign pr_shift  = {pr, acc[DIVIDEND_W-1]};
    assign fits      = pr_shift >= {1'b0, dvs};
    // the true difference is < divisor, so the low bits of the modular subtraction are exact
    assign pr_step   = pr_shift[DIVISOR_W-1:0] - (fits ? dvs : '0);
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end
    // next-state: zero divisor skips the iteration and goes straight to DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = divisor == '0 ? DONE : CALC;
            CALC: if (last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    // iteration datapath: latch operands on accept, then one restoring step per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            dvs <= '0;
            pr  <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= dividend;
            dvs <= divisor;
            pr  <= '0;
            cnt <= CW'(DIVIDEND_W - 1);
        end else if (state == CALC) begin
            acc <= {acc[DIVIDEND_W-2:0], fits};
            pr  <= pr_step;
            cnt <= cnt - CW'(1);
        end
    end
    // result registers change only on the transition into DONE, so they hold while backpressured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
        end else if (state == CALC && last) begin
            quotient    <= {acc[DIVIDEND_W-2:0], fits};
            remainder   <= pr_step;
            div_by_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_div_seq_radix2.sv
// tb_div_seq_radix2: directed checks of the radix-2 divider at 16/8 plus random vectors at 32/16
module tb_div_seq_radix2;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
    logic [15:0] dividend, quotient;
    logic [7:0]  divisor, remainder;
    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_div_by_zero, w_busy;
    logic [31:0] w_dividend, w_quotient, wa, weq;
    logic [15:0] w_divisor, w_remainder, wb, wer;
    int          compared = 0;
    int          mismatched = 0;
    int          n;
    logic [15:0] ra;
    logic [7:0]  rb;

    div_seq_radix2 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .busy(busy)
    );

    div_seq_radix2 #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .dividend(w_dividend), .divisor(w_divisor), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .quotient(w_quotient), .remainder(w_remainder), .div_by_zero(w_div_by_zero), .busy(w_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one request at a negedge, measure latency to out_valid, check result, then take it
    task automatic run(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                       input logic [7:0] er, input logic edz, input int elat, input string tag);
        int k;
        chk({tag, ".in_ready"}, in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".latency"}, k, elat);
        chk({tag, ".quotient"}, quotient, eq);
        chk({tag, ".remainder"}, remainder, er);
        chk({tag, ".dz"}, div_by_zero, edz);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".taken"}, out_valid, 0);
    endtask

    task automatic run_w(input logic [31:0] a, input logic [15:0] b, input logic [31:0] eq,
                         input logic [15:0] er, input logic edz, input int elat);
        int k;
        w_dividend = a;
        w_divisor  = b;
        w_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        k = 1;
        while (!w_out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wide.latency", k, elat);
        chk("wide.quotient", w_quotient, eq);
        chk("wide.remainder", w_remainder, er);
        chk("wide.dz", w_div_by_zero, edz);
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_dividend = '0; w_divisor = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.dz", div_by_zero, 0);
        chk("reset.busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'd100, 8'd7, 16'd14, 8'd2, 1'b0, 17, "100/7");
        run(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17, "FFFF/FF");
        run(16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 17, "5/9");
        run(16'd0, 8'd1, 16'd0, 8'd0, 1'b0, 17, "0/1");
        run(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1, "1234/0");
        run(16'd255, 8'd1, 16'd255, 8'd0, 1'b0, 17, "255/1");

        // backpressure: 50000/77 = 649 r 27, result held for 10 cycles while in_valid pulses
        dividend = 16'd50000;
        divisor  = 8'd77;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp.latency", n, 17);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2) == 0;
            dividend = 16'(i * 1111);
            divisor  = 8'(i);
            @(negedge clk);
            chk("bp.out_valid", out_valid, 1);
            chk("bp.quotient", quotient, 16'd649);
            chk("bp.remainder", remainder, 8'd27);
            chk("bp.in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp.taken", out_valid, 0);
        chk("bp.idle", busy, 0);

        // back-to-back: in_valid held high, out_ready high, 18-cycle spacing
        out_ready = 1'b1;
        ra = 16'($urandom);
        rb = 8'($urandom_range(1, 255));
        dividend = ra;
        divisor  = rb;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            weq = 32'(ra / rb);
            wer = 16'(ra % rb);
            if (k < 3) begin
                ra = 16'($urandom);
                rb = 8'($urandom_range(1, 255));
                dividend = ra;
                divisor  = rb;
            end else in_valid = 1'b0;
            n = 1;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("b2b.latency", n, 17);
            chk("b2b.quotient", quotient, weq);
            chk("b2b.remainder", remainder, wer);
            @(negedge clk);
            chk("b2b.in_ready", in_ready, 1);
        end
        out_ready = 1'b0;

        // reset at CALC cycle 5 aborts; earlier result must be cleared from the outputs
        dividend = 16'd40000;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk);
        chk("abort.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort.out_valid", out_valid, 0);
        chk("abort.quotient", quotient, 0);
        chk("abort.remainder", remainder, 0);
        chk("abort.dz", div_by_zero, 0);
        chk("abort.busy", busy, 0);
        chk("abort.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.no_result", out_valid, 0);
        run(16'd1000, 8'd3, 16'd333, 8'd1, 1'b0, 17, "after_abort");

        // wide instance: 32/16 random vectors, a quarter with small divisors including zero
        for (int i = 0; i < 1000; i++) begin
            wa = $urandom;
            wb = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (wb == 0) run_w(wa, wb, 32'hFFFF_FFFF, wa[15:0], 1'b1, 1);
            else run_w(wa, wb, wa / {16'd0, wb}, 16'(wa % {16'd0, wb}), 1'b0, 33);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
